// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory beat signals of the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: splits core loads/stores into word-aligned memory beats and extends read data
module load_store_unit #(
  parameter int WAIT_LIMIT = 16
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
  localparam logic [31:0] LAST_WAIT = 32'(WAIT_LIMIT - 1);
  state_t      state_q;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  m8_q;
  logic [63:0] w64_q;
  logic [29:0] wa_q;
  logic [31:0] lo_q;
  logic [31:0] cnt_q;
  logic [3:0]  mask_d;
  logic [7:0]  m8_d;
  logic [63:0] w64_d;
  logic        legal_d;
  logic        timeout;
  logic [63:0] rd64;
  logic [31:0] sh;
  logic [31:0] ext;
  assign mask_d  = bus.req_funct3[1] ? 4'b1111 : bus.req_funct3[0] ? 4'b0011 : 4'b0001;
  assign m8_d    = {4'b0000, mask_d} << bus.req_addr[1:0];
  assign w64_d   = {32'h0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
  assign legal_d = !(bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11 ||
                     (bus.req_funct3[2] && bus.req_store));
  assign timeout = (WAIT_LIMIT > 0) && (cnt_q == LAST_WAIT);
  // The word arriving now completes the load: it is lo for a single beat, hi after a split
  assign rd64    = (state_q == BEAT1) ? {bus.mem_rdata, lo_q} : {32'h0, bus.mem_rdata};
  assign sh      = 32'(rd64 >> {off_q, 3'b000});
  assign ext     = f3_q[1] ? sh :
                   f3_q[0] ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} :
                             {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
  // Request capture, beat sequencing, timeout and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      store_q         <= 1'b0;
      f3_q            <= '0;
      off_q           <= '0;
      m8_q            <= '0;
      w64_q           <= '0;
      wa_q            <= '0;
      lo_q            <= '0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.resp_err    <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_be      <= '0;
      bus.mem_wdata   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          store_q       <= bus.req_store;
          f3_q          <= bus.req_funct3;
          off_q         <= bus.req_addr[1:0];
          m8_q          <= m8_d;
          w64_q         <= w64_d;
          wa_q          <= bus.req_addr[31:2];
          cnt_q         <= '0;
          bus.req_ready <= 1'b0;
          if (legal_d) begin
            state_q       <= BEAT0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.req_store;
            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
            bus.mem_be    <= m8_d[3:0];
            bus.mem_wdata <= w64_d[31:0];
          end else begin
            state_q        <= DONE;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
          end
        end
        BEAT0, BEAT1: if (bus.mem_ack) begin
          cnt_q <= '0;
          if (state_q == BEAT0 && m8_q[7:4] != 4'b0000) begin
            state_q       <= BEAT1;
            lo_q          <= bus.mem_rdata;
            bus.mem_addr  <= {wa_q + 30'd1, 2'b00};
            bus.mem_be    <= m8_q[7:4];
            bus.mem_wdata <= w64_q[63:32];
          end else begin
            state_q        <= DONE;
            bus.mem_req    <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= store_q ? 32'h0 : ext;
          end
        end else if (timeout) begin
          state_q        <= DONE;
          bus.mem_req    <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b1;
          bus.resp_rdata <= '0;
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
        DONE: begin
          state_q        <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          bus.mem_we     <= 1'b0;
          bus.mem_addr   <= '0;
          bus.mem_be     <= '0;
          bus.mem_wdata  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory word interface. It converts core load/store requests (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-aligned memory beats with byte enables.
- Misaligned accesses that cross a word boundary are split into two beats. Read data is recombined, shifted and sign/zero-extended for register writeback.
- Sits between the execute stage (address from the ALU, store data from RD2) and the data memory. Byte order is little-endian: byte at the lowest address is bits [7:0].

Parameters:
- WAIT_LIMIT, 16, max cycles a beat waits for mem_ack before aborting with resp_err; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous active-high reset
- req_valid  input  1  core request valid
- req_ready  output  1  unit can accept a request (IDLE only)
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address (alu_result)
- req_wdata  input  32  store data (RD2), right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  illegal funct3 or timeout, valid with resp_valid
- mem_req  output  1  beat request, held until mem_ack
- mem_we  output  1  beat is a write
- mem_addr  output  32  word address, bits [1:0] = 00
- mem_be  output  4  byte-lane enables
- mem_wdata  output  32  lane-positioned write data
- mem_rdata  input  32  read word, valid in the mem_ack cycle
- mem_ack  input  1  beat completes this cycle

Behaviour:
- States: IDLE, BEAT0, BEAT1, DONE.
- Reset:
  - State goes to IDLE and the wait counter clears.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- IDLE:
  - req_ready=1.
  - On req_valid, capture store, funct3, addr, wdata and off=addr[1:0].
  - Legal funct3 -> BEAT0.
  - Illegal funct3 (011, 110, 111, or 1xx with store) -> DONE with err=1 and no memory beat.
- Lane math:
  - size mask is 0001 (byte), 0011 (half) or 1111 (word).
  - m8 = {4'b0, mask} << off (8 bits).
  - w64 = {32'b0, wdata} << (8*off).
  - Beat0 uses be=m8[3:0], wdata=w64[31:0], addr={addr[31:2],00}.
  - Beat1 uses be=m8[7:4], wdata=w64[63:32], addr=beat0 addr + 4, wrapping mod 2^32.
- Split condition: m8[7:4] != 0, i.e. half at off=3 or word at off 1..3.
- BEAT0 / BEAT1:
  - mem_req=1, with mem_we/addr/be/wdata stable while mem_req is held.
  - On mem_ack, a load captures mem_rdata into lo (BEAT0) or hi (BEAT1).
  - BEAT0 exit goes to BEAT1 if split, else DONE. BEAT1 exit goes to DONE.
  - mem_req deasserts in the cycle after ack.
  - The wait counter counts cycles in a beat without ack and resets on entry to each beat.
  - If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT, go to DONE with err=1 and drop mem_req. A split store may have already written beat0; this is not rolled back.
- DONE:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - Loads: r = ({hi, lo} >> 8*off)[31:0]. B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
  - Stores and errors: resp_rdata=0.
- Latency with same-cycle mem_ack:
  - Aligned or non-split access: accept at T, beat at T+1, resp_valid at T+2.
  - Split access: resp_valid at T+3.
- Only one request in flight; req_valid outside IDLE is ignored (not captured).
- Reset mid-operation: next cycle is IDLE with mem_req=0. No resp_valid is issued for the aborted request.
- mem_ack outside BEAT0/BEAT1 is ignored.

Test Plan:
- LW addr 0x10, mem word 0xDEADBEEF, ack immediate -> one beat at addr 0x10, be=1111; resp_rdata 0xDEADBEEF at T+2, err=0.
- LB addr 0x13, word 0x80112233 -> be=1000; resp_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x0E, data 0x0000ABCD -> be=1100, mem_wdata=0xABCD0000, mem_we=1, single beat; resp_rdata=0.
- LW addr 0x21, words 0x44332211 @0x20 and 0x88776655 @0x24 -> beats at 0x20 be=1110 then 0x24 be=0001; resp_rdata 0x55443322 at T+3.
- SW addr 0xFFFFFFFE, data 0xA1B2C3D4 -> beat0 0xFFFFFFFC be=1100 wdata=0xC3D40000; beat1 0x00000000 be=0011 wdata=0x0000A1B2.
- funct3=011 -> no mem_req, resp_err=1 at T+1. mem_ack held low -> err after WAIT_LIMIT=16 cycles, mem_req drops. Reset during BEAT0 -> IDLE next cycle, no resp_valid.
